// File: rtl/mem_wr_arbiter_pkg.sv
// Shared constants and types for the round-robin write arbiter and its store.
package mem_wr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned WIDTH   = 2;
  localparam int unsigned AW      = 2;

  // Pointer width matches NUM_REQ = 4, so ptr + 1 wraps modulo NUM_REQ for free.
  typedef logic [1:0] ptr_t;

endpackage

// File: rtl/mem_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import mem_wr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  ptr_t               ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic               valid
);

  ptr_t idx;

  always_comb begin
    win_oh = '0;
    valid  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + ptr_t'(k);
      if (!valid && req[idx]) begin
        win_oh[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Round-robin write arbiter owning a small 4x2 register store with a packed readout.
module mem_wr_arbiter
  import mem_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ_P = NUM_REQ,
  parameter int unsigned DEPTH_P   = DEPTH,
  parameter int unsigned WIDTH_P   = WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ_P-1:0]         req,
  input  logic [NUM_REQ_P*AW-1:0]      addr,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] wdata,
  input  logic                         clr,
  output logic [NUM_REQ_P-1:0]         gnt,
  output logic                         busy,
  output logic [DEPTH_P*WIDTH_P-1:0]   out
);

  logic [WIDTH_P-1:0]   mem_q [DEPTH_P];
  ptr_t                 ptr_q;
  logic [NUM_REQ_P-1:0] gnt_q;
  logic                 busy_q;

  logic [NUM_REQ_P-1:0] win_oh;
  logic                 win_valid;
  ptr_t                 win_idx;
  logic [AW-1:0]        addr_w;
  logic [WIDTH_P-1:0]   wdata_w;

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win_oh (win_oh),
    .valid  (win_valid)
  );

  // Encode the one-hot winner and mux out its address and data.
  always_comb begin
    win_idx = '0;
    addr_w  = '0;
    wdata_w = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      if (win_oh[i]) begin
        win_idx = ptr_t'(i);
        addr_w  = addr[AW*i +: AW];
        wdata_w = wdata[WIDTH_P*i +: WIDTH_P];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_P; i++) mem_q[i] <= '0;
      ptr_q  <= '0;
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH_P; i++) mem_q[i] <= '0;
      gnt_q  <= '0;
      busy_q <= |req;
    end else begin
      gnt_q  <= win_valid ? win_oh : '0;
      busy_q <= |(req & ~win_oh);
      if (win_valid) begin
        mem_q[addr_w] <= wdata_w;
        ptr_q         <= win_idx + ptr_t'(1);
      end
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < DEPTH_P; i++) out[(DEPTH_P-1-i)*WIDTH_P +: WIDTH_P] = mem_q[i];
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Randomised and directed bench for mem_wr_arbiter against a behavioural store model.
module tb_mem_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       clr = 1'b0;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  int         m_mem [4];
  int         m_ptr;
  logic [3:0] m_gnt;
  logic       m_busy;

  always #5 clk = ~clk;

  mem_wr_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .addr  (addr),
    .wdata (wdata),
    .clr   (clr),
    .gnt   (gnt),
    .busy  (busy),
    .out   (out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 0;
    m_ptr  = 0;
    m_gnt  = '0;
    m_busy = 1'b0;
  endfunction

  // One clock edge worth of the arbitration rules, applied to the current inputs.
  function automatic void model_edge();
    int w;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (w < 0 && req[idx]) w = idx;
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) m_mem[i] = 0;
      m_gnt  = '0;
      m_busy = (req != 0);
    end else if (w >= 0) begin
      m_mem[addr[2*w +: 2]] = int'(wdata[2*w +: 2]);
      m_gnt  = 4'(1 << w);
      m_ptr  = (w + 1) % 4;
      m_busy = ((req & ~m_gnt) != 0);
    end else begin
      m_gnt  = '0;
      m_busy = 1'b0;
    end
  endfunction

  function automatic logic [7:0] model_out();
    return 8'((m_mem[0] << 6) | (m_mem[1] << 4) | (m_mem[2] << 2) | m_mem[3]);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("gnt", 32'(gnt), 32'(m_gnt));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("out", 32'(out), 32'(model_out()));
  endtask

  // Asynchronous reset asserted mid-cycle, released just after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_out", 32'(out), 32'h00);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic void set_req(input int i, input logic [1:0] a, input logic [1:0] d);
    req[i]          = 1'b1;
    addr[2*i +: 2]  = a;
    wdata[2*i +: 2] = d;
  endfunction

  initial begin
    model_reset();
    do_reset();

    // Single requester 2 writes entry 3.
    set_req(2, 2'd3, 2'b10);
    step();
    check_eq("single_gnt", 32'(gnt), 32'h4);
    check_eq("single_out", 32'(out), 32'h02);
    req = '0;
    step();

    // Pointer is 3: requester 0 wins by wrap, then requester 2.
    req = 4'b0101;
    step();
    check_eq("rot_gnt0", 32'(gnt), 32'h1);
    step();
    check_eq("rot_gnt2", 32'(gnt), 32'h4);
    req = '0;
    step();

    // Same-address conflict from ptr = 0: last grant wins.
    do_reset();
    req = '0;
    set_req(1, 2'd0, 2'b01);
    set_req(3, 2'd0, 2'b11);
    step();
    check_eq("conf_first", 32'(out[7:6]), 32'h1);
    req[1] = 1'b0;
    step();
    check_eq("conf_last", 32'(out[7:6]), 32'h3);
    req = '0;
    step();

    // All four requesting continuously.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
      check_eq("rr_busy", 32'(busy), 32'h1);
    end

    // Clear blocks the write, request stays pending.
    req = '0;
    clr = 1'b1;
    set_req(0, 2'd1, 2'b11);
    step();
    check_eq("clr_gnt", 32'(gnt), 32'h0);
    check_eq("clr_busy", 32'(busy), 32'h1);
    check_eq("clr_out", 32'(out), 32'h00);
    clr = 1'b0;
    step();
    check_eq("clr_after", 32'(gnt), 32'h1);
    check_eq("clr_after_out", 32'(out), 32'h30);

    // Reset with requests in flight; first grant afterwards goes to requester 0.
    req = 4'b1111;
    step();
    step();
    do_reset();
    step();
    check_eq("post_rst_gnt", 32'(gnt), 32'h1);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      req   = 4'($urandom);
      addr  = 8'($urandom);
      wdata = 8'($urandom);
      clr   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
